// File: rtl/out_serializer.sv
// Byte FIFO feeding an MSB-first serial framer with optional odd parity and a one-cycle gap.
// Serial outputs are registered; ser_ready only advances the frame.
module out_serializer #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PARITY_EN = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             in,
  input  logic                   in_valid,
  input  logic                   ser_ready,
  output logic                   ser_data,
  output logic                   ser_frame,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic                   busy
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StShift, StParity, StGap} state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q, count_d;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic            parity_q, parity_d;
  logic            ser_data_q, ser_data_d;
  logic            ser_frame_q, ser_frame_d;
  logic            overflow_q;
  logic            full, empty, push, pop, drop;

  assign full  = (count_q == FullCount);
  assign empty = (count_q == '0);
  assign pop   = (state_q == StIdle) && !empty;
  // A full FIFO still takes a byte when the head leaves on the same edge.
  assign push  = in_valid && (!full || pop);
  assign drop  = in_valid && full && !pop;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          shift_d   = mem_q[rd_ptr_q];
          parity_d  = ~^mem_q[rd_ptr_q];
          bit_cnt_d = 3'd7;
          state_d   = StShift;
        end
      end
      StShift: begin
        if (ser_ready) begin
          shift_d   = {shift_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q - 3'd1;
          if (bit_cnt_q == 3'd0) begin
            state_d = (PARITY_EN != 0) ? StParity : StGap;
          end
        end
      end
      StParity: begin
        if (ser_ready) begin
          state_d = StGap;
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output registers are loaded from the next state so each bit appears right after its edge.
  always_comb begin
    ser_frame_d = (state_d == StShift) || (state_d == StParity);
    ser_data_d  = 1'b0;
    if (state_d == StShift) begin
      ser_data_d = shift_d[7];
    end else if (state_d == StParity) begin
      ser_data_d = parity_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      parity_q    <= 1'b0;
      ser_data_q  <= 1'b0;
      ser_frame_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      parity_q    <= parity_d;
      ser_data_q  <= ser_data_d;
      ser_frame_q <= ser_frame_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in;
    end
  end

  assign ser_data   = ser_data_q;
  assign ser_frame  = ser_frame_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_out_serializer.sv
// Bench for out_serializer: fixed vector table, frame-level hand sequences and a random run
// checked every cycle against a queue-based reference model.
module tb_out_serializer;

  localparam int unsigned DEPTH = 4;
  localparam int          PE    = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in = '0;
  logic       in_valid = 1'b0;
  logic       ser_ready = 1'b1;
  logic       ser_data, ser_frame, overflow, busy;
  logic [2:0] fifo_count;

  logic [7:0] in0 = '0;
  logic       in_valid0 = 1'b0;
  logic       ser_ready0 = 1'b1;
  logic       ser_data0, ser_frame0, overflow0, busy0;
  logic [2:0] fifo_count0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  out_serializer #(.DEPTH(DEPTH), .PARITY_EN(1)) u_dut (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .ser_ready(ser_ready),
    .ser_data(ser_data), .ser_frame(ser_frame), .fifo_count(fifo_count),
    .overflow(overflow), .busy(busy)
  );

  out_serializer #(.DEPTH(DEPTH), .PARITY_EN(0)) u_dut0 (
    .clk(clk), .reset(reset), .in(in0), .in_valid(in_valid0), .ser_ready(ser_ready0),
    .ser_data(ser_data0), .ser_frame(ser_frame0), .fifo_count(fifo_count0),
    .overflow(overflow0), .busy(busy0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a byte queue plus the number of serial slots left in the current frame.
  logic [7:0] mq[$];
  int         m_slots = 0;
  int         m_gap = 0;
  int         m_sent = 0;
  logic [7:0] m_cur = '0;
  logic       m_ovf = 1'b0;
  bit         m_pop, m_push;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_slots = 0;
      m_gap   = 0;
      m_sent  = 0;
      m_cur   = '0;
      m_ovf   = 1'b0;
    end else begin
      m_pop  = (m_slots == 0) && (m_gap == 0) && (mq.size() > 0);
      m_push = in_valid && ((mq.size() < DEPTH) || m_pop);
      if (in_valid && !m_push) m_ovf = 1'b1;
      if (m_gap != 0) begin
        m_gap = 0;
      end else if (m_slots > 0 && ser_ready) begin
        m_slots--;
        m_sent++;
        if (m_slots == 0) m_gap = 1;
      end
      if (m_pop) begin
        m_cur   = mq.pop_front();
        m_slots = 8 + PE;
        m_sent  = 0;
      end
      if (m_push) mq.push_back(in);
    end
  end

  function automatic logic m_exp_data();
    if (m_slots == 0) return 1'b0;
    if (m_sent < 8) return m_cur[7 - m_sent];
    return ~^m_cur;
  endfunction

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_frame", 32'(ser_frame), 32'(m_slots > 0));
      chk("model_data", 32'(ser_data), 32'(m_exp_data()));
      chk("model_count", 32'(fifo_count), 32'(mq.size()));
      chk("model_overflow", 32'(overflow), 32'(m_ovf));
      chk("model_busy", 32'(busy), 32'((m_slots > 0) || (m_gap > 0) || (mq.size() > 0)));
    end
  end

  // Frame collector: records each completed frame as {byte, parity} and its start cycle.
  logic [8:0] mon_bits = '0;
  int         mon_n = 0;
  int         cyc = 0;
  int         cur_start = 0;
  logic       prev_frame = 1'b0;
  logic [8:0] got_frames[$];
  int         got_start[$];

  always @(negedge clk) begin
    #2;
    cyc++;
    if (!reset) begin
      mon_n      = 0;
      prev_frame = 1'b0;
    end else begin
      if (ser_frame && !prev_frame) cur_start = cyc;
      prev_frame = ser_frame;
      if (ser_frame && ser_ready) begin
        mon_bits = {mon_bits[7:0], ser_data};
        mon_n++;
        if (mon_n == 8 + PE) begin
          got_frames.push_back(mon_bits);
          got_start.push_back(cur_start);
          mon_n = 0;
        end
      end
    end
  end

  // Called at a falling edge; inputs change 1 time unit later, outputs are seen at the next fall.
  task automatic cyc_drive(input logic v, input logic [7:0] d, input logic r);
    #1;
    in_valid  = v;
    in        = d;
    ser_ready = r;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name, input int max);
    int n;
    n = 0;
    while (busy && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(busy), 32'(0));
  endtask

  function automatic logic [8:0] frm(input logic [7:0] b);
    return {b, ~^b};
  endfunction

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       r;
    logic       f_e;
    logic       d_e;
    logic       b_e;
    logic [2:0] c_e;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic r,
                              input logic f, input logic sd, input logic b, input logic [2:0] c);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.f_e = f; t.d_e = sd; t.b_e = b; t.c_e = c;
    return t;
  endfunction

  localparam int NV = 20;
  vec_t       vt [NV];
  logic [7:0] b6 [6];
  int         rises[$];
  int         fhigh, fones, fbad;
  logic       prev0;

  initial begin
    // 0xA5 frame with ready held high
    vt[0]  = mk(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1);
    vt[1]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
    vt[2]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0);
    vt[3]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
    vt[4]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0);
    vt[5]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0);
    vt[6]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
    vt[7]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0);
    vt[8]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
    vt[9]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
    vt[10] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
    vt[11] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    // 0xB4 with ready 1,0,0,1 while shifting
    vt[12] = mk(1'b1, 8'hB4, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1);
    vt[13] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
    vt[14] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0);
    vt[15] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0);
    vt[16] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0);
    vt[17] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
    vt[18] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
    vt[19] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0);

    b6[0] = 8'h11; b6[1] = 8'h22; b6[2] = 8'h33;
    b6[3] = 8'h44; b6[4] = 8'h55; b6[5] = 8'h66;

    // Reset state
    #1 reset = 1'b0;
    #1;
    chk("rst_data", 32'(ser_data), 32'(0));
    chk("rst_frame", 32'(ser_frame), 32'(0));
    chk("rst_count", 32'(fifo_count), 32'(0));
    chk("rst_overflow", 32'(overflow), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_frame0", 32'(ser_frame0), 32'(0));
    chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);

    // Vector table
    for (int i = 0; i < NV; i++) begin
      cyc_drive(vt[i].v, vt[i].d, vt[i].r);
      chk($sformatf("vec%0d_frame", i), 32'(ser_frame), 32'(vt[i].f_e));
      chk($sformatf("vec%0d_data", i), 32'(ser_data), 32'(vt[i].d_e));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].b_e));
      chk($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vt[i].c_e));
    end
    cyc_drive(1'b0, 8'h00, 1'b1);
    wait_idle("vec_idle", 40);

    // Back-to-back 0x01, 0x00
    @(negedge clk);
    got_frames.delete(); got_start.delete();
    cyc_drive(1'b1, 8'h01, 1'b1);
    cyc_drive(1'b1, 8'h00, 1'b1);
    cyc_drive(1'b0, 8'h00, 1'b1);
    wait_idle("b2b_idle", 40);
    chk("b2b_nframes", 32'(got_frames.size()), 32'(2));
    if (got_frames.size() == 2) begin
      chk("b2b_frame0", 32'(got_frames[0]), 32'({8'h01, 1'b0}));
      chk("b2b_frame1", 32'(got_frames[1]), 32'({8'h00, 1'b1}));
      chk("b2b_spacing", 32'(got_start[1] - got_start[0]), 32'(11));
    end

    // Six consecutive pushes into a depth-4 FIFO
    @(negedge clk);
    got_frames.delete(); got_start.delete();
    for (int k = 0; k < 6; k++) begin
      cyc_drive(1'b1, b6[k], 1'b1);
      if (k == 4) begin
        chk("ovf_count_full", 32'(fifo_count), 32'(4));
        chk("ovf_not_yet", 32'(overflow), 32'(0));
      end
      if (k == 5) begin
        chk("ovf_count_drop", 32'(fifo_count), 32'(4));
        chk("ovf_set", 32'(overflow), 32'(1));
      end
    end
    cyc_drive(1'b0, 8'h00, 1'b1);
    wait_idle("ovf_idle", 100);
    chk("ovf_nframes", 32'(got_frames.size()), 32'(5));
    for (int k = 0; k < 5; k++) begin
      if (k < got_frames.size()) chk($sformatf("ovf_frame%0d", k), 32'(got_frames[k]),
                                     32'(frm(b6[k])));
    end

    // Random traffic against the model
    @(negedge clk);
    for (int i = 0; i < 400; i++) begin
      cyc_drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    cyc_drive(1'b0, 8'h00, 1'b1);
    wait_idle("rand_idle", 100);

    // Reset mid-frame with two bytes queued
    @(negedge clk);
    got_frames.delete(); got_start.delete();
    cyc_drive(1'b1, 8'h91, 1'b1);
    cyc_drive(1'b1, 8'h42, 1'b1);
    cyc_drive(1'b1, 8'h24, 1'b1);
    cyc_drive(1'b0, 8'h00, 1'b1);
    cyc_drive(1'b0, 8'h00, 1'b1);
    chk("mid_count", 32'(fifo_count), 32'(2));
    chk("mid_frame", 32'(ser_frame), 32'(1));
    chk("mid_bit4", 32'(ser_data), 32'(1));
    #3 reset = 1'b0;
    #1;
    chk("async_frame", 32'(ser_frame), 32'(0));
    chk("async_data", 32'(ser_data), 32'(0));
    chk("async_busy", 32'(busy), 32'(0));
    chk("async_count", 32'(fifo_count), 32'(0));
    chk("async_overflow", 32'(overflow), 32'(0));
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    cyc_drive(1'b1, 8'h3C, 1'b1);
    cyc_drive(1'b0, 8'h00, 1'b1);
    wait_idle("post_rst_idle", 40);
    chk("post_rst_nframes", 32'(got_frames.size()), 32'(1));
    if (got_frames.size() == 1) chk("post_rst_frame", 32'(got_frames[0]), 32'(frm(8'h3C)));

    // Parity disabled: two 0xFF bytes back-to-back
    @(negedge clk);
    #1 in_valid0 = 1'b1; in0 = 8'hFF;
    @(negedge clk);
    chk("np_count_first", 32'(fifo_count0), 32'(1));
    chk("np_frame_first", 32'(ser_frame0), 32'(0));
    fhigh = 0; fones = 0; fbad = 0; prev0 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ser_frame0 && !prev0) rises.push_back(i);
      prev0 = ser_frame0;
      if (ser_frame0) begin
        fhigh++;
        if (ser_data0) fones++;
      end else if (ser_data0) begin
        fbad++;
      end
      if (i == 0) begin
        chk("np_count_pushpop", 32'(fifo_count0), 32'(1));
        #1 in_valid0 = 1'b0;
      end
    end
    chk("np_frame_cycles", 32'(fhigh), 32'(16));
    chk("np_ones", 32'(fones), 32'(16));
    chk("np_data_outside", 32'(fbad), 32'(0));
    chk("np_nrises", 32'(rises.size()), 32'(2));
    if (rises.size() == 2) chk("np_spacing", 32'(rises[1] - rises[0]), 32'(10));
    chk("np_busy_end", 32'(busy0), 32'(0));

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/out_serializer.md
OUT_SERIALIZER -- requirements
Module: out_serializer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: FIFO entries; a power of two, at least 2.
REQ-002 SHALL have parameter PARITY_EN, default 1: 1 appends an odd-parity bit to each frame; 0 omits it.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port in  input  8  byte from the upstream core's registered out bus.
REQ-006 SHALL have port in_valid  input  1  in holds a byte to enqueue this cycle.
REQ-007 SHALL have port ser_ready  input  1  pad side accepts the current serial bit this cycle.
REQ-008 SHALL have port ser_data  output  1  serial bit, MSB first.
REQ-009 SHALL have port ser_frame  output  1  high while ser_data carries a data or parity bit.
REQ-010 SHALL have port fifo_count  output  $clog2(DEPTH)+1  bytes held in FIFO.
REQ-011 SHALL have port overflow  output  1  sticky flag: a byte was dropped.
REQ-012 SHALL have port busy  output  1  FSM not in IDLE, or fifo_count nonzero.

Function
REQ-013 SHALL buffer bytes in a DEPTH-entry circular FIFO; full is fifo_count==DEPTH; empty is fifo_count==0.
REQ-014 SHALL accept a push when in_valid=1 and (not full, or a pop occurs in the same cycle).
REQ-015 SHALL drop the byte and set overflow=1 when in_valid=1, FIFO full and no same-cycle pop; overflow clears only on reset; FIFO contents unchanged.
REQ-016 SHALL wrap read and write pointers modulo DEPTH with no loss or duplication across the wrap.
REQ-017 SHALL update fifo_count as +1 on push only, -1 on pop only, unchanged on push+pop or neither.
REQ-018 SHALL implement FSM states IDLE, SHIFT, PARITY, GAP.
REQ-019 IDLE: ser_frame=0, ser_data=0; if FIFO not empty, pop head into shift register and bit counter=7, next state SHIFT.
REQ-020 SHIFT: ser_frame=1, ser_data=shift[7]; on ser_ready=1 shift left by one and decrement counter; after bit 0 is accepted, next state PARITY if PARITY_EN=1, else GAP; on ser_ready=0 hold all state.
REQ-021 PARITY: ser_frame=1, ser_data = XNOR-reduction of the popped byte (odd parity over 9 bits); on ser_ready=1 next state GAP, else hold.
REQ-022 GAP: ser_frame=0, ser_data=0 for exactly one cycle, then IDLE.
REQ-023 Latency: a byte pushed at edge N into empty FIFO with FSM in IDLE is popped at edge N+1; its MSB appears on ser_data after edge N+1.
REQ-024 Throughput with ser_ready held 1: 11 cycles per byte with PARITY_EN=1, 10 with PARITY_EN=0.
REQ-025 ser_data and ser_frame SHALL be driven directly from registers (no combinational path from in, in_valid or ser_ready).
REQ-026 A push arriving during any FSM state SHALL be enqueued and SHALL not disturb the frame in progress.

Reset
REQ-027 While reset=0, SHALL force FSM=IDLE, pointers=0, fifo_count=0, shift register=0, counter=0, ser_data=0, ser_frame=0, overflow=0, busy=0, immediately (asynchronously).
REQ-028 Reset asserted mid-frame SHALL abort the frame and discard all FIFO contents; after release, the first output is from a byte pushed after release.
REQ-029 Release of reset SHALL take effect on the first rising clk edge after reset returns to 1.

Verification
REQ-030 Push 0xA5, ser_ready=1 -> ser_frame high 9 cycles, ser_data 1,0,1,0,0,1,0,1 then parity 1; one GAP cycle; busy returns to 0.
REQ-031 Push 0x01 then 0x00 back-to-back -> frames 00000001+parity 0, then 00000000+parity 1; 11 cycles apart.
REQ-032 Push 6 bytes on consecutive cycles, DEPTH=4, ser_ready=1 -> byte 1 popped on entry; bytes 2-5 queued (fifo_count=4); byte 6 dropped, overflow=1; bytes 1-5 transmitted in order.
REQ-033 Toggle ser_ready 1,0,0,1 during SHIFT -> each bit held for its stalled cycles; no bit skipped or repeated.
REQ-034 Assert reset during bit 4 of a frame with 2 bytes queued -> all outputs 0 immediately; after release, push 0x3C -> only 0x3C frame observed.
REQ-035 PARITY_EN=0, push 0xFF -> 8 frame cycles, all 1s, then GAP; next byte starts 10 cycles after the previous one.
